// File: rtl/game_text_writer_if.sv
// Character write port of the run-time text buffer.
// The producer drives wr_valid/wr_char and holds them until wr_ready.
interface game_text_writer_if;
    logic       wr_valid;
    logic [6:0] wr_char;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_char,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_char,
        output wr_ready
    );
endinterface

// File: rtl/game_text_writer.sv
// Writable 16x8 character buffer with auto-advancing cursor.
// Read side is a drop-in replacement for the per-screen text ROMs.
module game_text_writer #(
    parameter logic [6:0] CLEAR_CODE = 7'h20,
    parameter int         COLS_LOG2  = 4,
    parameter int         ROWS_LOG2  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    game_text_writer_if.slave   wr,
    input  logic                nl_req,
    input  logic                clr_req,
    input  logic [7:0]          char_xy,
    output logic [6:0]          char_code,
    output logic [7:0]          cursor_xy,
    output logic                busy,
    output logic                full
);

    localparam int AW    = COLS_LOG2 + ROWS_LOG2;
    localparam int DEPTH = 1 << AW;

    localparam logic [AW-1:0]        ADDR_ONE  = 1;
    localparam logic [AW-1:0]        ADDR_LAST = '1;
    localparam logic [ROWS_LOG2-1:0] ROW_ONE   = 1;
    localparam logic [COLS_LOG2-1:0] COL_ONE   = 1;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [AW-1:0]        clr_cnt;
    logic [AW-1:0]        cur;
    logic [COLS_LOG2-1:0] col;
    logic [ROWS_LOG2-1:0] row;
    logic                 last_col;
    logic                 last_row;
    logic                 full_q;

    logic                 ready;
    logic                 wr_fire;
    logic                 nl_fire;

    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [6:0]           mem_data;
    logic [6:0]           mem [DEPTH];

    logic                 unused_xy;

    assign col      = cur[COLS_LOG2-1:0];
    assign row      = cur[AW-1:COLS_LOG2];
    assign last_col = &col;
    assign last_row = &row;

    assign wr_fire  = wr.wr_valid && ready;
    assign nl_fire  = (state == S_IDLE) && nl_req
                      && !clr_req && !full_q;

    assign cursor_xy = {1'b0, cur};
    assign full      = full_q;
    assign unused_xy = char_xy[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_CLEAR: begin
                if (!clr_req && clr_cnt == ADDR_LAST) begin
                    state_nx = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr_req) begin
                    state_nx = S_CLEAR;
                end
            end
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        ready    = 1'b0;
        mem_we   = 1'b0;
        mem_addr = cur;
        mem_data = wr.wr_char;
        unique case (state)
            S_CLEAR: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_cnt;
                mem_data = CLEAR_CODE;
            end
            S_IDLE: begin
                ready  = !full_q && !nl_req && !clr_req;
                mem_we = wr.wr_valid && ready;
            end
        endcase
    end

    assign wr.wr_ready = ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (clr_req) begin
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_ONE;
        end
    end

    // Cursor saturates at the last cell; full then blocks writes/newlines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= '0;
            full_q <= 1'b0;
        end else if (clr_req) begin
            cur    <= '0;
            full_q <= 1'b0;
        end else if (nl_fire) begin
            if (last_row) begin
                full_q <= 1'b1;
            end else begin
                cur <= {row + ROW_ONE, {COLS_LOG2{1'b0}}};
            end
        end else if (wr_fire) begin
            if (cur == ADDR_LAST) begin
                full_q <= 1'b1;
            end else if (!last_col) begin
                cur <= {row, col + COL_ONE};
            end else begin
                cur <= {row + ROW_ONE, {COLS_LOG2{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    // Read-first: a same-cycle write is seen one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_code <= CLEAR_CODE;
        end else begin
            char_code <= mem[char_xy[AW-1:0]];
        end
    end

endmodule
